// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared constants, state encoding and code helper for the DAC sweep controller
package dac_pkg;

    localparam int CODE_W = 12;

    localparam logic [3:0] CTRL_A = 4'b0011;
    localparam logic [3:0] CTRL_B = 4'b1011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_EOW,
        ST_DWELL,
        ST_DONE
    } state_t;

    // 13-bit sum so a step near the top of the range cannot wrap past 4095
    function automatic logic [CODE_W-1:0] next_code(
        input logic [CODE_W-1:0] cur,
        input logic [CODE_W-1:0] step,
        input logic [CODE_W-1:0] stop
    );
        logic [CODE_W:0] sum;
        sum = {1'b0, cur} + {1'b0, step};
        if (sum > {1'b0, stop}) begin
            return stop;
        end
        return sum[CODE_W-1:0];
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - loadable down-counter that stops at zero and flags it
module dwell_timer #(
    parameter int Width = 29
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] value,
    output logic             zero
);

    logic [Width-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - Width'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/dac_sweep_ctrl.sv
// rtl/dac_sweep_ctrl.sv - steps a DAC code from start to stop, one SPI write plus dwell per point
module dac_sweep_ctrl
    import dac_pkg::*;
#(
    parameter int         Width = 29,
    parameter logic [3:0] CtrlA = CTRL_A,
    parameter logic [3:0] CtrlB = CTRL_B
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              eow_i,
    input  logic              chsel_i,
    input  logic [CODE_W-1:0] code_start_i,
    input  logic [CODE_W-1:0] code_stop_i,
    input  logic [CODE_W-1:0] step_i,
    input  logic [Width-1:0]  dwell_i,
    output logic              strw_o,
    output logic [15:0]       din_o,
    output logic [CODE_W-1:0] code_o,
    output logic              busy_o,
    output logic              done_o
);

    state_t            state, state_nxt;
    logic              chsel_q;
    logic [CODE_W-1:0] stop_q, step_q, code_q, code_nxt;
    logic [Width-1:0]  dwell_q;
    logic              abort_q;
    logic              timer_load, timer_zero;
    logic              accept;
    logic [3:0]        ctrl_sel;

    dwell_timer #(.Width(Width)) u_dwell_timer (
        .clk   (clk_i),
        .rst   (rst_i),
        .load  (timer_load),
        .value (dwell_q),
        .zero  (timer_zero)
    );

    // abort beats a simultaneous start
    assign accept   = (state == ST_IDLE) && start_i && !abort_i;
    assign ctrl_sel = ((state == ST_IDLE) ? chsel_i : chsel_q) ? CtrlB : CtrlA;

    always_comb begin
        state_nxt  = state;
        code_nxt   = code_q;
        timer_load = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_SEND;
                    code_nxt  = code_start_i;
                end
            end
            ST_SEND: begin
                state_nxt = abort_i ? ST_IDLE : ST_WAIT_EOW;
            end
            ST_WAIT_EOW: begin
                // the frame in flight always completes; abort only acts at its end
                if (eow_i) begin
                    timer_load = 1'b1;
                    state_nxt  = (abort_i || abort_q) ? ST_IDLE : ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (abort_i) begin
                    state_nxt = ST_IDLE;
                end else if (timer_zero) begin
                    if (code_q >= stop_q) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_SEND;
                        code_nxt  = next_code(code_q, step_q, stop_q);
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            chsel_q <= 1'b0;
            stop_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            code_q  <= '0;
            abort_q <= 1'b0;
            strw_o  <= 1'b0;
            done_o  <= 1'b0;
            busy_o  <= 1'b0;
            din_o   <= 16'h0000;
        end else begin
            state   <= state_nxt;
            code_q  <= code_nxt;
            abort_q <= (state == ST_WAIT_EOW) && !eow_i && (abort_q || abort_i);
            strw_o  <= (state_nxt == ST_SEND);
            done_o  <= (state_nxt == ST_DONE);
            busy_o  <= (state_nxt != ST_IDLE);
            if (accept) begin
                chsel_q <= chsel_i;
                stop_q  <= code_stop_i;
                step_q  <= (step_i == '0) ? CODE_W'(1) : step_i;
                dwell_q <= dwell_i;
            end
            if (state_nxt == ST_SEND) begin
                din_o <= {ctrl_sel, code_nxt};
            end
        end
    end

    assign code_o = code_q;

endmodule

// File: doc/dac_sweep_ctrl.md
DAC_SWEEP_CTRL -- requirements
Module: dac_sweep_ctrl

Interface
REQ-001 Parameter Width, default 29: dwell counter width in bits.
REQ-002 Parameter CtrlA, default 4'b0011: control nibble for DAC-A.
REQ-003 Parameter CtrlB, default 4'b1011: control nibble for DAC-B.
REQ-004 clk_i  in  1  system clock; the only clock.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 start_i  in  1  one-cycle pulse; requests a sweep.
REQ-007 abort_i  in  1  level; requests sweep termination.
REQ-008 eow_i  in  1  one-cycle end-of-write pulse from the SPI DAC writer.
REQ-009 chsel_i  in  1  channel select, sampled on start: 0 = DAC-A, 1 = DAC-B.
REQ-010 code_start_i  in  12  first code of the sweep.
REQ-011 code_stop_i  in  12  last code of the sweep.
REQ-012 step_i  in  12  code increment per point.
REQ-013 dwell_i  in  Width  settle cycles after each write.
REQ-014 strw_o  out  1  one-cycle write strobe to the SPI DAC writer.
REQ-015 din_o  out  16  DAC word {ctrl[3:0], code[11:0]}.
REQ-016 code_o  out  12  code currently being written or held.
REQ-017 busy_o  out  1  high in every state except IDLE.
REQ-018 done_o  out  1  one-cycle pulse when a sweep completes normally.

Function
REQ-019 The FSM SHALL have states IDLE, SEND, WAIT_EOW, DWELL and DONE.
REQ-020 IDLE: on start_i, capture chsel_i, code_stop_i, step_i and dwell_i, load code = code_start_i, and go to SEND.
REQ-021 SEND: assert strw_o for exactly one cycle, then go to WAIT_EOW.
REQ-022 din_o SHALL equal {CtrlA or CtrlB, code} from the SEND cycle until the next code update.
REQ-023 WAIT_EOW: on eow_i, load the dwell counter with the captured dwell value and go to DWELL.
REQ-024 DWELL: if counter != 0, decrement it; if counter == 0 and code >= stop, go to DONE; if counter == 0 and code < stop, set code = min(code + step, stop) and go to SEND.
REQ-025 The code addition SHALL be 13-bit, saturating at stop; code SHALL never wrap past 4095.
REQ-026 A captured step of 0 SHALL be treated as 1.
REQ-027 If code_start > code_stop, exactly one write (of code_start) SHALL occur, followed by DONE.
REQ-028 DONE: assert done_o for one cycle, then go to IDLE.
REQ-029 Latency: start_i in cycle t gives strw_o in cycle t+1; eow_i in cycle t gives the next strw_o in cycle t+dwell+2.
REQ-030 start_i SHALL be ignored while busy_o = 1.
REQ-031 abort_i in SEND, DWELL or DONE SHALL force IDLE on the next edge, with no done_o and no further strw_o.
REQ-032 abort_i in WAIT_EOW SHALL be latched, so that the SPI frame is never cut; on eow_i the FSM SHALL go to IDLE without done_o.
REQ-033 abort_i and start_i together in IDLE: abort SHALL win and the sweep SHALL not start.
REQ-034 eow_i outside WAIT_EOW SHALL be ignored.
REQ-035 All outputs SHALL be registered.

Reset
REQ-036 On rst_i = 1 at a clock edge: state = IDLE, strw_o = 0, done_o = 0, busy_o = 0, din_o = 16'h0000, code_o = 12'h000, dwell counter = 0, abort latch = 0.
REQ-037 rst_i mid-sweep SHALL abandon the sweep immediately with no done_o.

Structure
REQ-038 A shared package dac_pkg SHALL hold CtrlA, CtrlB, the state encoding, and the 12-bit code width constant.
REQ-039 The dwell down-counter SHALL be a sub-module dwell_timer (inputs load, value; output zero flag).
REQ-040 dac_sweep_ctrl SHALL sit upstream of spi_write_dac, with strw_o to strw_i, din_o to din_i, and eow_o to eow_i.

Verification
REQ-041 Basic ramp: start = 0, stop = 12, step = 4, dwell = 3, chsel = 0, writer model returns eow 10 cycles after each strw -> din_o = 0x3000, 0x3004, 0x3008, 0x300C; 4 strobes; done_o once; strobe spacing 10 + 3 + 2 cycles.
REQ-042 Saturation: start = 0xFF0, stop = 0xFFF, step = 0x00A, chsel = 1 -> din_o = 0xBFF0, 0xBFFA, 0xBFFF; no wrap.
REQ-043 Edge cases: step = 0 with start = 5, stop = 7 -> codes 5, 6, 7; start = 9, stop = 3 -> a single write of 9, then done_o.
REQ-044 Abort in WAIT_EOW -> no new strw_o; IDLE the cycle after eow_i; done_o stays 0.
REQ-045 Abort in DWELL -> IDLE next cycle, busy_o = 0.
REQ-046 Reset and ignored inputs: rst_i asserted during DWELL -> all outputs at reset values next cycle; start_i pulsed while busy -> no effect on the sweep.
